// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turbo_pkg
// Purpose  : Shared types for the turbo puncture/serializer block: output FSM
//            state encoding, rate-select encodings and the packed turbo
//            symbol {last, par2, par1, sys} carried through the symbol FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYS  = 2'd1,
    ST_P1   = 2'd2,
    ST_P2   = 2'd3
  } state_e;

  localparam logic RATE_1_3 = 1'b0;
  localparam logic RATE_1_2 = 1'b1;

  localparam int unsigned SYM_W = 4;

  typedef struct packed {
    logic last;
    logic par2;
    logic par1;
    logic sys;
  } sym_t;

endpackage
`default_nettype wire

// File: rtl/turbo_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module   : turbo_sym_fifo
// Purpose  : Synchronous FIFO for turbo symbols. Read data is the head entry
//            (show-ahead); pointers carry one extra MSB so full and empty are
//            told apart when the index bits match.
// Ports    : clk, reset (async, active-high)
//            push_i/wdata_i  - write request and data (ignored while full)
//            pop_i           - read request (ignored while empty)
//            rdata_o         - head entry
//            full_o/empty_o  - status flags
// Revision : 1.0 - initial release
// ============================================================================
module turbo_sym_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO refuses the write even when a read frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/turbo_puncture_serializer.sv
`default_nettype none
// ============================================================================
// Module   : turbo_puncture_serializer
// Purpose  : Buffers turbo symbols {sys, par1, par2} and serializes them as a
//            rate 1/3 (sys,p1,p2) or punctured rate 1/2 (sys,p1 / sys,p2
//            alternating) channel bitstream over a valid/ready handshake.
// Ports    : clk, reset (async, active-high)
//            rate_sel_i                 - 0: rate 1/3, 1: rate 1/2 (frame start)
//            in_valid_i/in_ready_o      - input symbol handshake
//            in_sys_i/in_par1_i/in_par2_i/in_last_i - symbol fields
//            out_valid_o/out_ready_i    - output bit handshake
//            out_bit_o/out_last_o       - serial bit, final-bit-of-frame flag
//            frame_done_o               - pulse on the out_last handshake
//            sym_count_o                - symbols emitted in frame (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module turbo_puncture_serializer
  import turbo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rate_sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sys_i,
  input  logic             in_par1_i,
  input  logic             in_par2_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_bit_o,
  output logic             out_last_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] sym_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  sym_t             hold_q, hold_d;
  logic             rate_q, rate_d;
  logic             phase_q, phase_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sym_t             in_sym;
  sym_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             final_bit;
  logic             sym_end;

  assign in_sym     = {in_last_i, in_par2_i, in_par1_i, in_sys_i};
  assign in_ready_o = !fifo_full;

  turbo_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid_i),
    .wdata_i (in_sym),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rate_d      = rate_q;
    phase_d     = phase_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    sym_end     = 1'b0;
    final_bit   = 1'b0;
    out_bit_o   = 1'b0;
    out_valid_o = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: ;
      ST_SYS: begin
        out_bit_o = hold_q.sys;
        // Punctured rate keeps par1 on even symbols and par2 on odd ones.
        if (out_ready_i)
          state_d = (rate_q == RATE_1_2 && phase_q) ? ST_P2 : ST_P1;
      end
      ST_P1: begin
        out_bit_o = hold_q.par1;
        final_bit = (rate_q == RATE_1_2);
        if (out_ready_i) begin
          if (final_bit) sym_end = 1'b1;
          else           state_d = ST_P2;
        end
      end
      ST_P2: begin
        out_bit_o = hold_q.par2;
        final_bit = 1'b1;
        if (out_ready_i) sym_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sym_end) begin
      state_d = ST_IDLE;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
      if (rate_q == RATE_1_2) phase_d = ~phase_q;
      if (hold_q.last) begin
        phase_d  = 1'b0;
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end

    // Loading straight after a symbol end avoids a bubble between symbols.
    // Using active_d lets a frame that starts right after a last symbol
    // re-latch the rate selection.
    if ((state_q == ST_IDLE || sym_end) && !fifo_empty) begin
      fifo_pop = 1'b1;
      hold_d   = fifo_head;
      state_d  = ST_SYS;
      if (!active_d) begin
        rate_d   = rate_sel_i;
        active_d = 1'b1;
      end
    end
  end

  assign out_last_o   = final_bit && hold_q.last;
  assign frame_done_o = sym_end && hold_q.last;
  assign sym_count_o  = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      rate_q   <= RATE_1_3;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rate_q   <= rate_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turbo_puncture_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_puncture_serializer
// Purpose  : Scoreboard bench for turbo_puncture_serializer. Accepted symbols
//            are expanded by a frame-level reference model into expected bits;
//            an independent monitor compares every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_puncture_serializer;
  import turbo_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rate_sel, in_valid, in_ready;
  logic          in_sys, in_par1, in_par2, in_last;
  logic          out_valid, out_ready, out_bit, out_last, frame_done;
  logic [CW-1:0] sym_count;

  turbo_puncture_serializer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rate_sel_i   (rate_sel),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sys_i     (in_sys),
    .in_par1_i    (in_par1),
    .in_par2_i    (in_par2),
    .in_last_i    (in_last),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_bit_o    (out_bit),
    .out_last_o   (out_last),
    .frame_done_o (frame_done),
    .sym_count_o  (sym_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard + reference model ----------------
  typedef struct { logic b; logic l; int sc; } exp_t;
  exp_t sb[$];

  int   m_idx      = 0;    // symbols of the current frame already modelled
  logic m_rate     = 1'b0;
  bit   m_in_frame = 0;

  function automatic void sb_push(input logic b, input logic l, input int sc);
    exp_t e;
    e.b = b; e.l = l; e.sc = sc;
    sb.push_back(e);
  endfunction

  // v = {last, par2, par1, sys}; rate is the rate the bench chose for the frame
  function automatic void model_sym(input logic [3:0] v, input logic rate);
    if (!m_in_frame) begin
      m_rate = rate; m_in_frame = 1; m_idx = 0;
    end
    sb_push(v[0], 1'b0, m_idx);
    if (m_rate == RATE_1_3) begin
      sb_push(v[1], 1'b0, m_idx);
      sb_push(v[2], v[3], m_idx);
    end else begin
      sb_push((m_idx % 2 == 0) ? v[1] : v[2], v[3], m_idx);
    end
    m_idx++;
    if (v[3]) m_in_frame = 0;
  endfunction

  // ---------------- output backpressure ----------------
  int bp_mode = 0;  // 0: always ready, 1: random, 2: never ready
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit   prev_stall = 0;
  logic prev_bit, prev_last;
  bit   first_pending = 1;
  int   t_first = 0;
  int   last_span = -1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall    = 0;
        first_pending = 1;
      end else begin
        if (prev_stall) begin
          chk(out_valid == 1'b1, "stall_valid_held", out_valid, 1);
          chk(out_bit == prev_bit, "stall_bit_held", out_bit, prev_bit);
          chk(out_last == prev_last, "stall_last_held", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_output", out_bit, -1);
          end else begin
            e = sb.pop_front();
            chk(out_bit == e.b, "out_bit", out_bit, e.b);
            chk(out_last == e.l, "out_last", out_last, e.l);
            chk(frame_done == e.l, "frame_done", frame_done, e.l);
            chk(sym_count == CW'(e.sc), "sym_count", sym_count, e.sc);
            if (first_pending) begin
              t_first = cyc; first_pending = 0;
            end
            if (e.l) begin
              last_span = cyc - t_first; first_pending = 1;
            end
          end
        end else begin
          chk(frame_done == 1'b0, "frame_done_no_hs", frame_done, 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_bit   = out_bit;
        prev_last  = out_last;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_sym(input logic [3:0] v, input logic rate);
    int  n   = 0;
    bit  acc = 0;
    in_valid = 1'b1;
    {in_last, in_par2, in_par1, in_sys} = v;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      tick();
      n++;
      if (!acc && n > 500) begin
        chk(1'b0, "timeout_input_accept", n, 500);
        break;
      end
    end
    if (acc) model_sym(v, rate);
    in_valid = 1'b0;
  endtask

  function automatic logic [3:0] rnd_sym(input logic last);
    return {last, 3'($urandom_range(0, 7))};
  endfunction

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
      if (++n > 3000) begin
        chk(1'b0, "timeout_drain", sb.size(), 0);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_out_valid();
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (++n > 100) begin
        chk(1'b0, "timeout_out_valid", out_valid, 1);
        break;
      end
    end
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         acc_n, idx, len, n;
    bit         a;
    logic       r;
    logic [3:0] v;

    reset = 1'b1; in_valid = 1'b0; rate_sel = RATE_1_3;
    {in_last, in_par2, in_par1, in_sys} = 4'b0;
    repeat (2) tick();
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_bit == 1'b0, "rst_out_bit", out_bit, 0);
    chk(out_last == 1'b0, "rst_out_last", out_last, 0);
    chk(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
    chk(sym_count == '0, "rst_sym_count", sym_count, 0);
    reset = 1'b0;
    repeat (2) tick();

    // 1) rate 1/3 fixed frame, no backpressure, no gaps between bits
    bp_mode = 0; rate_sel = RATE_1_3;
    send_sym(4'b0101, RATE_1_3);
    send_sym(4'b0110, RATE_1_3);
    send_sym(4'b1011, RATE_1_3);
    wait_drain();
    chk(last_span == 8, "t1_no_gaps_span", last_span, 8);

    // 2) two back-to-back rate 1/2 frames; second must restart with par1
    rate_sel = RATE_1_2;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) send_sym(rnd_sym(i == 3), RATE_1_2);
    wait_drain();

    // 3) random backpressure, random rates, lengths and input gaps
    bp_mode = 1;
    for (int f = 0; f < 6; f++) begin
      r = 1'($urandom_range(0, 1));
      rate_sel = r;
      len = (f == 0) ? 1 : int'($urandom_range(2, 7));
      for (int i = 0; i < len; i++) begin
        send_sym(rnd_sym(i == len - 1), r);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain();
    end

    // 4) stalled output: FIFO fills (DEPTH entries plus one in the hold reg)
    bp_mode = 2; tick(); tick();
    rate_sel = RATE_1_3;
    acc_n = 0; idx = 0;
    for (int c = 0; c < 20 && idx < 10; c++) begin
      v = rnd_sym(idx == DEPTH);
      in_valid = 1'b1;
      {in_last, in_par2, in_par1, in_sys} = v;
      @(negedge clk); a = in_ready;
      tick();
      if (a) begin
        model_sym(v, RATE_1_3); idx++; acc_n++;
      end
    end
    in_valid = 1'b0;
    chk(acc_n == DEPTH + 1, "t4_accepted_count", acc_n, DEPTH + 1);
    chk(in_ready == 1'b0, "t4_in_ready_full", in_ready, 0);
    bp_mode = 0;
    @(posedge clk); #2;
    chk(in_ready == 1'b0, "t4_in_ready_before_pop", in_ready, 0);
    repeat (3) tick();
    chk(in_ready == 1'b1, "t4_in_ready_after_pop", in_ready, 1);
    wait_drain();

    // 5) rate_sel toggled mid-frame must be ignored until the next frame
    rate_sel = RATE_1_3;
    send_sym(rnd_sym(1'b0), RATE_1_3);
    wait_out_valid();
    for (int i = 1; i < 6; i++) begin
      rate_sel = 1'($urandom_range(0, 1));
      send_sym(rnd_sym(i == 5), RATE_1_3);
    end
    rate_sel = RATE_1_2;
    wait_drain();
    for (int i = 0; i < 3; i++) send_sym(rnd_sym(i == 2), RATE_1_2);
    wait_drain();

    // 6) reset after two of five symbols have been emitted
    rate_sel = RATE_1_3;
    for (int i = 0; i < 5; i++) send_sym(rnd_sym(i == 4), RATE_1_3);
    n = 0;
    forever begin
      @(negedge clk);
      if (sym_count == CW'(2)) break;
      if (++n > 100) begin
        chk(1'b0, "timeout_t6_count", sym_count, 2);
        break;
      end
    end
    #1 reset = 1'b1;
    sb.delete();
    m_in_frame = 0;
    tick();
    chk(out_valid == 1'b0, "t6_out_valid", out_valid, 0);
    chk(sym_count == '0, "t6_sym_count", sym_count, 0);
    chk(in_ready == 1'b1, "t6_in_ready", in_ready, 1);
    chk(frame_done == 1'b0, "t6_frame_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk(out_valid == 1'b0, "t6_fifo_empty", out_valid, 0);
    rate_sel = RATE_1_2;
    for (int i = 0; i < 3; i++) send_sym(rnd_sym(i == 2), RATE_1_2);
    wait_drain();

    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
